svsg_count_core: RTL and testbench
==================================

Name: svsg_count_core

Overview:
- Wishbone-programmable prescaled single-digit counter for the user project area.
- Sits directly upstream of the seven-segment encoder stage that drives the 8-bit svsg pad bus.
- Produces the current digit, a decimal-point bit and a wrap pulse; management SoC firmware configures and reads it over the Wishbone slave port.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base; decode on wbs_adr_i[31:4].
- PRE_W, 24, prescaler register/counter width.
- PRE_RST, 24'd9_999_999, PRESCALE reset value (one tick per 10^7 clocks).

Ports:
- clk  in  1  system clock (wb_clk_i)
- reset  in  1  asynchronous, active-high reset (wb_rst_i)
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lane selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- digit_o  out  4  current count digit to the seven-segment encoder
- dp_o  out  1  decimal-point bit to the encoder
- wrap_o  out  1  one-cycle pulse on counter wrap

Behaviour:
- Register map, word offset = adr[3:2], selected when adr[31:4] == BASE_ADDR[31:4]:
  - 0x0 CTRL: [0] en, [1] dir (0 up, 1 down), [2] dec (0 hex 0-15, 1 decimal 0-9), [3] dp_blink. Remaining bits read 0.
  - 0x4 PRESCALE: [PRE_W-1:0]. Per-byte writes honour wbs_sel_i.
  - 0x8 COUNT: [3:0] digit, R/W.
  - 0xC STATUS: [0] wrap_sticky, write-1-to-clear; [1] en mirror, RO.
- Bytes not selected by wbs_sel_i are not written. CTRL, COUNT and STATUS are written only when sel[0]=1.
- Wishbone handshake:
  - wbs_ack_o rises one cycle after a cyc&stb request with a matching address, and stays high for exactly one cycle.
  - While ack is high, the request is not re-sampled, so no double ack.
  - Non-matching address: no ack, no side effects.
  - wbs_dat_o is valid in the ack cycle and is 0 otherwise.
  - Writes take effect at the ack edge.
- Prescaler:
  - pcnt counts 0..PRESCALE while en=1.
  - At pcnt==PRESCALE: tick=1 and pcnt returns to 0. PRESCALE=0 gives a tick every cycle.
  - en=0 holds pcnt at 0.
  - Any PRESCALE write resets pcnt to 0 in the same edge.
- Counter, updated on tick:
  - Up: digit+1. At the top value (15 hex, 9 dec) it goes to 0 and wraps. In dec mode, any digit >9 also goes to 0 and wraps.
  - Down: digit-1. From 0 it goes to the top value and wraps.
- Wrap: wrap_o pulses high for the cycle after the updating edge (registered), and wrap_sticky is set. If a W1C clear coincides with a new wrap, set wins.
- COUNT write:
  - Stores wdata[3:0]. In dec mode, values >9 saturate to 9.
  - A COUNT write and a tick in the same cycle: the write wins, no wrap is generated, and pcnt still restarts.
- dp_o: when dp_blink=1, toggles on every tick; when dp_blink=0, held 0 and the toggle state is cleared.
- Reset:
  - All outputs 0 (wbs_ack_o, wbs_dat_o, digit_o, dp_o, wrap_o).
  - CTRL=0, COUNT=0, pcnt=0, wrap_sticky=0, PRESCALE=PRE_RST.
- Reset asserted mid-transaction drops any pending ack immediately (asynchronous); the transaction is lost.
- Latency: register write to the first visible effect on digit_o is 1 clock (COUNT). For CTRL en 0→1, the first tick comes PRESCALE+1 clocks after the write.

Decomposition:
- Shared package svsg_pkg holds:
  - register offset constants REG_CTRL/REG_PRESCALE/REG_COUNT/REG_STATUS;
  - CTRL bit index constants;
  - HEX_TOP=4'd15 and DEC_TOP=4'd9.
- One natural sub-module, svsg_prescaler: pcnt counter with en, load-clear and tick output.
- The Wishbone decode and digit counter stay in svsg_count_core.

Test Plan:
- Reset with PRESCALE default → digit_o=0, dp_o=0, wrap_o=0, ack=0. Read 0x4 → 0x0098967F with one-cycle ack.
- Write PRESCALE=3, CTRL=0x1 → digit increments every 4 clocks: 0,1,…,15. At 15→0, wrap_o pulses 1 cycle and STATUS reads 0x3. Write STATUS=1 → reads 0x2.
- CTRL=0x7 (en, down, dec), COUNT=0, PRESCALE=0 → digit sequence 9,8,…,0,9 with a wrap on the 0→9 step.
- Dec mode: write COUNT=0xC → reads 9. Switch to hex, write COUNT=0xC, switch to dec up → next tick gives 0 plus a wrap.
- COUNT write landing on the same edge as a tick (PRESCALE=0): digit equals the written value, no wrap_o, and counting resumes from it.
- Access to BASE_ADDR+0x10 → no ack within 4 cycles, registers unchanged. Assert reset during a pending ack → ack drops the same cycle, registers at reset values.

Source files
------------

// File: rtl/svsg_pkg.sv
// Shared register map, CTRL bit positions and digit-step helper for the svsg counter.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package svsg_pkg;

  // Word offsets, taken from byte address bits [3:2]
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_COUNT    = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIR = 1;
  localparam int CTRL_DEC = 2;
  localparam int CTRL_DPB = 3;

  // Highest digit value in each counting mode
  localparam logic [3:0] HEX_TOP = 4'd15;
  localparam logic [3:0] DEC_TOP = 4'd9;

  typedef struct packed {
    logic       wrap;
    logic [3:0] digit;
  } step_t;

  // One counting step. Up-counting treats anything at or above the mode's top
  // as the wrap point, so a leftover hex value in decimal mode wraps to 0.
  function automatic step_t step_digit(input logic [3:0] digit,
                                       input logic       down,
                                       input logic       dec);
    step_t      r;
    logic [3:0] top;
    top     = dec ? DEC_TOP : HEX_TOP;
    r.wrap  = 1'b0;
    r.digit = digit;
    if (down) begin
      if (digit == 4'd0) begin
        r.digit = top;
        r.wrap  = 1'b1;
      end else begin
        r.digit = digit - 4'd1;
      end
    end else begin
      if (digit >= top) begin
        r.digit = 4'd0;
        r.wrap  = 1'b1;
      end else begin
        r.digit = digit + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/svsg_prescaler.sv
// Prescaler: pcnt runs 0..prescale while enabled and flags a tick on the terminal count.
// Latency: tick is combinational from pcnt; first tick prescale+1 clocks after enable/clear.
// Backpressure: none; clr and en=0 both park pcnt at 0.
module svsg_prescaler #(
  parameter int PRE_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pcnt;

  assign tick = en & (pcnt == prescale);

  // Free-running count, restarted by a PRESCALE write, by disable, or at the terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/svsg_count_core.sv
// Wishbone-programmable prescaled single-digit counter feeding the seven-segment encoder.
// Latency: ack and read data one clock after a matching request; COUNT write visible on digit_o next clock.
// Backpressure: none; one-cycle ack, request ignored while ack is high, unmatched addresses never ack.
module svsg_count_core
  import svsg_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR = 32'h3000_0000,
  parameter int               PRE_W     = 24,
  parameter logic [PRE_W-1:0] PRE_RST   = 24'd9_999_999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  digit_o,
  output logic        dp_o,
  output logic        wrap_o
);

  logic             addr_hit;
  logic             req;
  logic [1:0]       reg_sel;
  logic             wr;
  logic             wr_ctrl;
  logic             wr_pre;
  logic             wr_count;
  logic             wr_status;
  logic [3:0]       ctrl;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_mask;
  logic             wrap_sticky;
  logic             tick;
  logic             wrap_evt;
  step_t            step;
  logic [31:0]      rd_dat;
  logic             unused_bits;

  assign addr_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req       = wbs_cyc_i & wbs_stb_i & addr_hit & ~wbs_ack_o;
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr        = req & wbs_we_i;
  assign wr_ctrl   = wr & wbs_sel_i[0] & (reg_sel == REG_CTRL);
  assign wr_pre    = wr & (reg_sel == REG_PRESCALE);
  assign wr_count  = wr & wbs_sel_i[0] & (reg_sel == REG_COUNT);
  assign wr_status = wr & wbs_sel_i[0] & (reg_sel == REG_STATUS);

  assign step      = step_digit(digit_o, ctrl[CTRL_DIR], ctrl[CTRL_DEC]);
  // A COUNT write on a tick edge overrides the step, so its wrap is dropped too
  assign wrap_evt  = tick & step.wrap & ~wr_count;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

  svsg_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (ctrl[CTRL_EN]),
    .clr      (wr_pre),
    .prescale (prescale),
    .tick     (tick)
  );

  // Expand byte selects to a per-bit write mask for PRESCALE
  always_comb begin
    pre_mask = '0;
    for (int b = 0; b < PRE_W; b++) begin
      pre_mask[b] = wbs_sel_i[b/8];
    end
  end

  // Read mux, sampled into wbs_dat_o on the request edge
  always_comb begin
    rd_dat = '0;
    case (reg_sel)
      REG_CTRL:     rd_dat = {28'd0, ctrl};
      REG_PRESCALE: rd_dat = 32'(prescale);
      REG_COUNT:    rd_dat = {28'd0, digit_o};
      REG_STATUS:   rd_dat = {30'd0, ctrl[CTRL_EN], wrap_sticky};
      default:      rd_dat = '0;
    endcase
  end

  // Wishbone handshake: single-cycle ack, read data only during the ack cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rd_dat : '0;
    end
  end

  // Configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      prescale <= PRE_RST;
    end else begin
      if (wr_ctrl) ctrl <= wbs_dat_i[3:0];
      if (wr_pre)  prescale <= (prescale & ~pre_mask) | (wbs_dat_i[PRE_W-1:0] & pre_mask);
    end
  end

  // Digit counter and registered wrap pulse; firmware writes win over a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_o <= '0;
      wrap_o  <= 1'b0;
    end else begin
      wrap_o <= wrap_evt;
      if (wr_count) begin
        digit_o <= (ctrl[CTRL_DEC] && (wbs_dat_i[3:0] > DEC_TOP)) ? DEC_TOP : wbs_dat_i[3:0];
      end else if (tick) begin
        digit_o <= step.digit;
      end
    end
  end

  // Sticky wrap flag, write-1-to-clear; a coincident wrap keeps it set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_sticky <= 1'b0;
    end else if (wrap_evt) begin
      wrap_sticky <= 1'b1;
    end else if (wr_status && wbs_dat_i[0]) begin
      wrap_sticky <= 1'b0;
    end
  end

  // Decimal point toggles per tick while blinking, forced low otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_o <= 1'b0;
    end else if (!ctrl[CTRL_DPB]) begin
      dp_o <= 1'b0;
    end else if (tick) begin
      dp_o <= ~dp_o;
    end
  end

endmodule

// File: tb/tb_svsg_count_core.sv
// Directed bench for svsg_count_core: register access, counting modes, wrap and reset handling.
module tb_svsg_count_core;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        reset;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [3:0]  digit;
  logic        dp;
  logic        wrap;

  int n_checks = 0;
  int n_fail   = 0;

  svsg_count_core dut (
    .clk       (clk),
    .reset     (reset),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .digit_o   (digit),
    .dp_o      (dp),
    .wrap_o    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // Bus write; returns at ack edge + 1
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic got;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_checks++;
    if (got !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_write_ack addr=%h: ack seen=%0b, required 1", a, got);
    end
  endtask

  // Bus read; returns at ack edge + 1 with captured data
  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic got;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    got = 1'b0;
    d = 32'hDEAD_BEEF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        got = 1'b1;
        d = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    n_checks++;
    if (got !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_read_ack addr=%h: ack seen=%0b, required 1", a, got);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (digit !== 4'd0) begin n_fail++; $display("FAIL reset_digit: got %0d, required 0", digit); end
    n_checks++; if (dp !== 1'b0)    begin n_fail++; $display("FAIL reset_dp: got %0b, required 0", dp); end
    n_checks++; if (wrap !== 1'b0)  begin n_fail++; $display("FAIL reset_wrap: got %0b, required 0", wrap); end
    n_checks++; if (ack !== 1'b0)   begin n_fail++; $display("FAIL reset_ack: got %0b, required 0", ack); end
    n_checks++; if (rdat !== 32'd0) begin n_fail++; $display("FAIL reset_dat: got %h, required 0", rdat); end
    reset = 1'b0;
    @(posedge clk); #1;
    wb_read(BASE + 32'h4, d);
    n_checks++; if (d !== 32'h0098_967F) begin n_fail++; $display("FAIL reset_prescale: got %h, required 0098967f", d); end
    @(posedge clk); #1;
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle: ack=%0b, required 0", ack); end
    n_checks++; if (rdat !== 32'd0) begin n_fail++; $display("FAIL dat_after_ack: got %h, required 0", rdat); end
  endtask

  task automatic test_count_up();
    logic [31:0] d;
    logic [3:0]  exp_d;
    logic        exp_w;
    wb_write(BASE + 32'h4, 32'd3, 4'hF);
    wb_write(BASE + 32'h0, 32'h1, 4'h1);
    for (int k = 1; k <= 16; k++) begin
      repeat (4) @(posedge clk);
      #1;
      exp_d = 4'(k % 16);
      exp_w = (k == 16);
      n_checks++; if (digit !== exp_d) begin n_fail++; $display("FAIL up_digit step %0d: got %0d, required %0d", k, digit, exp_d); end
      n_checks++; if (wrap !== exp_w)  begin n_fail++; $display("FAIL up_wrap step %0d: got %0b, required %0b", k, wrap, exp_w); end
    end
    @(posedge clk); #1;
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_wrap_width: got %0b, required 0", wrap); end
    wb_read(BASE + 32'hC, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL status_after_wrap: got %h, required 3", d); end
    wb_write(BASE + 32'hC, 32'h1, 4'h1);
    wb_read(BASE + 32'hC, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL status_w1c: got %h, required 2", d); end
    wb_write(BASE + 32'h0, 32'h0, 4'h1);
  endtask

  task automatic test_down_dec();
    logic [3:0] exp_d;
    logic       exp_w;
    wb_write(BASE + 32'h4, 32'd0, 4'hF);
    wb_write(BASE + 32'h8, 32'd0, 4'h1);
    wb_write(BASE + 32'h0, 32'h7, 4'h1);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      exp_d = (k == 11) ? 4'd9 : 4'(10 - k);
      exp_w = (k == 1) || (k == 11);
      n_checks++; if (digit !== exp_d) begin n_fail++; $display("FAIL down_digit step %0d: got %0d, required %0d", k, digit, exp_d); end
      n_checks++; if (wrap !== exp_w)  begin n_fail++; $display("FAIL down_wrap step %0d: got %0b, required %0b", k, wrap, exp_w); end
    end
    wb_write(BASE + 32'h0, 32'h4, 4'h1);
  endtask

  task automatic test_dec_saturate();
    logic [31:0] d;
    wb_write(BASE + 32'h0, 32'h4, 4'h1);
    wb_write(BASE + 32'h8, 32'hC, 4'h1);
    wb_read(BASE + 32'h8, d);
    n_checks++; if (d !== 32'h9) begin n_fail++; $display("FAIL dec_saturate: got %h, required 9", d); end
    wb_write(BASE + 32'h0, 32'h0, 4'h1);
    wb_write(BASE + 32'h8, 32'hC, 4'h1);
    wb_read(BASE + 32'h8, d);
    n_checks++; if (d !== 32'hC) begin n_fail++; $display("FAIL hex_count_write: got %h, required c", d); end
    wb_write(BASE + 32'h0, 32'h5, 4'h1);
    @(posedge clk); #1;
    n_checks++; if (digit !== 4'd0) begin n_fail++; $display("FAIL dec_over_digit: got %0d, required 0", digit); end
    n_checks++; if (wrap !== 1'b1)  begin n_fail++; $display("FAIL dec_over_wrap: got %0b, required 1", wrap); end
    @(posedge clk); #1;
    n_checks++; if (digit !== 4'd1) begin n_fail++; $display("FAIL dec_after_wrap: got %0d, required 1", digit); end
    wb_write(BASE + 32'h0, 32'h0, 4'h1);
  endtask

  task automatic test_count_write_tick();
    logic [31:0] d;
    wb_write(BASE + 32'hC, 32'h1, 4'h1);
    wb_write(BASE + 32'h4, 32'd0, 4'hF);
    wb_write(BASE + 32'h8, 32'hE, 4'h1);
    wb_write(BASE + 32'h0, 32'h1, 4'h1);
    // Lands two edges later, exactly when the tick would take 15 -> 0
    wb_write(BASE + 32'h8, 32'h5, 4'h1);
    n_checks++; if (digit !== 4'd5) begin n_fail++; $display("FAIL wr_tick_digit: got %0d, required 5", digit); end
    n_checks++; if (wrap !== 1'b0)  begin n_fail++; $display("FAIL wr_tick_wrap: got %0b, required 0", wrap); end
    @(posedge clk); #1;
    n_checks++; if (digit !== 4'd6) begin n_fail++; $display("FAIL wr_tick_resume1: got %0d, required 6", digit); end
    @(posedge clk); #1;
    n_checks++; if (digit !== 4'd7) begin n_fail++; $display("FAIL wr_tick_resume2: got %0d, required 7", digit); end
    wb_read(BASE + 32'hC, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL wr_tick_status: got %h, required 2", d); end
    wb_write(BASE + 32'h0, 32'h0, 4'h1);
  endtask

  task automatic test_dp_blink();
    wb_write(BASE + 32'h4, 32'd0, 4'hF);
    wb_write(BASE + 32'h0, 32'h9, 4'h1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_checks++; if (dp !== 1'(k % 2)) begin n_fail++; $display("FAIL dp_toggle step %0d: got %0b, required %0b", k, dp, 1'(k % 2)); end
    end
    wb_write(BASE + 32'h0, 32'h1, 4'h1);
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++; if (dp !== 1'b0) begin n_fail++; $display("FAIL dp_cleared: got %0b, required 0", dp); end
    end
    wb_write(BASE + 32'h0, 32'h0, 4'h1);
  endtask

  task automatic test_bad_addr();
    logic [31:0] d;
    logic        saw;
    wb_write(BASE + 32'h8, 32'h3, 4'h1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; wdat = 32'h1; sel = 4'hF;
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) saw = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL bad_addr_ack: ack seen=%0b, required 0", saw); end
    @(posedge clk); #1;
    n_checks++; if (digit !== 4'd3) begin n_fail++; $display("FAIL bad_addr_digit: got %0d, required 3", digit); end
    wb_read(BASE + 32'h0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL bad_addr_ctrl: got %h, required 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wb_write(BASE + 32'h0, 32'h8, 4'h1);
    wb_write(BASE + 32'h8, 32'h7, 4'h1);
    wb_write(BASE + 32'h4, 32'h55, 4'h1);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
    @(posedge clk); #1;
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack_pending: got %0b, required 1", ack); end
    reset = 1'b1;
    #1;
    n_checks++; if (ack !== 1'b0)   begin n_fail++; $display("FAIL mid_ack_drop: got %0b, required 0", ack); end
    n_checks++; if (rdat !== 32'd0) begin n_fail++; $display("FAIL mid_dat_drop: got %h, required 0", rdat); end
    n_checks++; if (digit !== 4'd0) begin n_fail++; $display("FAIL mid_digit: got %0d, required 0", digit); end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    wb_read(BASE + 32'h0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_ctrl: got %h, required 0", d); end
    wb_read(BASE + 32'h4, d);
    n_checks++; if (d !== 32'h0098_967F) begin n_fail++; $display("FAIL mid_prescale: got %h, required 0098967f", d); end
    wb_read(BASE + 32'h8, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_count: got %h, required 0", d); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down_dec();
    test_dec_saturate();
    test_count_write_tick();
    test_dp_blink();
    test_bad_addr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
